// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : Hazard and forwarding controller for the IF/DE/EX/ME/WB core.
//               - Operand forwarding to EX from ME (priority) and WB.
//               - Load-use detection with a configurable stall length.
//               - Whole-pipeline freeze while data memory is not ready.
//               - DE/EX squash on a taken branch resolved in EX.
//               - Saturating stall-cycle counter and sticky memory timeout.
// Ports       :
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   RUWr_me/wb, rd_me/wb         register write enable / destination, ME and WB
//   rs1_ex, rs2_ex, rd_ex        EX source and destination registers
//   MemRd_ex                     EX instruction is a load
//   rs1_de, rs2_de, use_rs*_de   DE source registers and their use flags
//   br_taken_ex                  taken branch/jump resolved in EX
//   dmem_req_me, dmem_ready      ME data-memory handshake
//   FUASrc, FUBSrc               operand select: 00 regfile, 01 ME, 10 WB
//   stall_pc, stall_de           hold PC / IF-DE register
//   bubble_ex, flush_de          NOP into DE/EX / clear IF/DE
//   freeze                       hold every pipeline register
//   stall_cnt                    saturating count of stall_pc cycles
//   mem_timeout                  sticky: freeze lasted TIMEOUT cycles
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RUWr_me,
    input  logic              RUWr_wb,
    input  logic [REG_AW-1:0] rd_me,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic [REG_AW-1:0] rs1_ex,
    input  logic [REG_AW-1:0] rs2_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              MemRd_ex,
    input  logic [REG_AW-1:0] rs1_de,
    input  logic [REG_AW-1:0] rs2_de,
    input  logic              use_rs1_de,
    input  logic              use_rs2_de,
    input  logic              br_taken_ex,
    input  logic              dmem_req_me,
    input  logic              dmem_ready,
    output logic [1:0]        FUASrc,
    output logic [1:0]        FUBSrc,
    output logic              stall_pc,
    output logic              stall_de,
    output logic              bubble_ex,
    output logic              flush_de,
    output logic              freeze,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              mem_timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // LOAD_LAT is limited to 1..15, so four bits always hold the remaining
    // stall count.
    localparam int               c_LU_W       = 4;
    localparam logic [c_LU_W-1:0] c_LU_INIT   = c_LU_W'(LOAD_LAT - 1);
    localparam logic [c_LU_W-1:0] c_LU_ONE    = c_LU_W'(1);
    localparam bit               c_MULTI_LU   = (LOAD_LAT > 1);
    localparam bit               c_ZERO_HARD  = (ZERO_REG != 0);

    // Wait counter saturates at TIMEOUT, so it only needs to reach that value.
    localparam int                  c_WAIT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = c_WAIT_W'(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_LU_STALL = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Forwarding (purely combinational, independent of reset and state)
    // ------------------------------------------------------------------------
    logic              w_me_src_ok;
    logic              w_wb_src_ok;
    logic [REG_AW-1:0] w_rs_ex  [2];
    logic [1:0]        w_fwd_sel[2];

    // A write to the hardwired zero register never produces a usable value.
    assign w_me_src_ok = RUWr_me && !(c_ZERO_HARD && (rd_me == '0));
    assign w_wb_src_ok = RUWr_wb && !(c_ZERO_HARD && (rd_wb == '0));

    assign w_rs_ex[0] = rs1_ex;
    assign w_rs_ex[1] = rs2_ex;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic w_hit_me;
        logic w_hit_wb;

        assign w_hit_me = w_me_src_ok && (rd_me == w_rs_ex[gi]);
        assign w_hit_wb = w_wb_src_ok && (rd_wb == w_rs_ex[gi]);

        // ME holds the younger result, so it wins over WB.
        assign w_fwd_sel[gi] = w_hit_me ? 2'b01 :
                               (w_hit_wb ? 2'b10 : 2'b00);
    end : g_fwd

    assign FUASrc = w_fwd_sel[0];
    assign FUBSrc = w_fwd_sel[1];

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    logic w_freeze_raw;
    logic w_hz;

    assign w_freeze_raw = dmem_req_me && !dmem_ready;

    assign w_hz = MemRd_ex
               && !(c_ZERO_HARD && (rd_ex == '0))
               && ((use_rs1_de && (rs1_de == rd_ex))
                || (use_rs2_de && (rs2_de == rd_ex)));

    // ------------------------------------------------------------------------
    // Control decode: freeze > branch > load-use
    // ------------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nx;
    logic [c_LU_W-1:0] r_lu_cnt;
    logic [c_LU_W-1:0] w_lu_nx;
    logic              w_stall;
    logic              w_bubble;
    logic              w_flush;

    always_comb begin
        w_stall    = 1'b0;
        w_bubble   = 1'b0;
        w_flush    = 1'b0;
        w_state_nx = r_state;
        w_lu_nx    = r_lu_cnt;

        if (rst) begin
            // Registers are cleared by the sequential block; outputs stay low.
            w_state_nx = ST_IDLE;
            w_lu_nx    = '0;
        end else if (w_freeze_raw) begin
            // Everything holds, including the load-use countdown.
            w_stall = 1'b1;
        end else if (br_taken_ex) begin
            // The DE instruction is squashed, so any hazard it raised is moot.
            w_flush    = 1'b1;
            w_bubble   = 1'b1;
            w_state_nx = ST_IDLE;
            w_lu_nx    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hz) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                        if (c_MULTI_LU) begin
                            w_state_nx = ST_LU_STALL;
                            w_lu_nx    = c_LU_INIT;
                        end
                    end
                end
                ST_LU_STALL: begin
                    // EX already holds the bubble inserted on entry.
                    w_stall = 1'b1;
                    w_lu_nx = r_lu_cnt - c_LU_ONE;
                    if (r_lu_cnt <= c_LU_ONE) begin
                        w_state_nx = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_lu_nx    = '0;
                end
            endcase
        end
    end

    assign stall_pc  = w_stall;
    assign stall_de  = w_stall;
    assign bubble_ex = w_bubble;
    assign flush_de  = w_flush;
    assign freeze    = w_freeze_raw && !rst;

    // ------------------------------------------------------------------------
    // State, statistics and timeout registers
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_lu_cnt      <= '0;
            r_stall_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_lu_cnt <= w_lu_nx;

            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end

            if (w_freeze_raw) begin
                if (r_wait_cnt != c_WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                end
                // Set on the edge where the counter arrives at TIMEOUT.
                if (r_wait_cnt >= c_WAIT_LAST) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign mem_timeout = r_mem_timeout;

endmodule : hazard_forward_unit
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_unit
// Description : Self-checking bench for hazard_forward_unit. Directed scenario
//               tasks plus a randomized run against a behavioural model that
//               tracks "stall cycles still owed" rather than FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

    localparam int REG_AW   = 5;
    localparam int LOAD_LAT = 3;
    localparam int ZERO_REG = 1;
    localparam int CNT_W    = 5;
    localparam int TIMEOUT  = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              RUWr_me, RUWr_wb;
    logic [REG_AW-1:0] rd_me, rd_wb, rs1_ex, rs2_ex, rd_ex, rs1_de, rs2_de;
    logic              MemRd_ex, use_rs1_de, use_rs2_de, br_taken_ex;
    logic              dmem_req_me, dmem_ready;
    logic [1:0]        FUASrc, FUBSrc;
    logic              stall_pc, stall_de, bubble_ex, flush_de, freeze;
    logic [CNT_W-1:0]  stall_cnt;
    logic              mem_timeout;

    hazard_forward_unit #(
        .REG_AW  (REG_AW),
        .LOAD_LAT(LOAD_LAT),
        .ZERO_REG(ZERO_REG),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RUWr_me    (RUWr_me),
        .RUWr_wb    (RUWr_wb),
        .rd_me      (rd_me),
        .rd_wb      (rd_wb),
        .rs1_ex     (rs1_ex),
        .rs2_ex     (rs2_ex),
        .rd_ex      (rd_ex),
        .MemRd_ex   (MemRd_ex),
        .rs1_de     (rs1_de),
        .rs2_de     (rs2_de),
        .use_rs1_de (use_rs1_de),
        .use_rs2_de (use_rs2_de),
        .br_taken_ex(br_taken_ex),
        .dmem_req_me(dmem_req_me),
        .dmem_ready (dmem_ready),
        .FUASrc     (FUASrc),
        .FUBSrc     (FUBSrc),
        .stall_pc   (stall_pc),
        .stall_de   (stall_de),
        .bubble_ex  (bubble_ex),
        .flush_de   (flush_de),
        .freeze     (freeze),
        .stall_cnt  (stall_cnt),
        .mem_timeout(mem_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: stall cycles still owed, consecutive freeze
    // cycles, stall counter and sticky timeout.
    int m_left = 0;
    int m_wait = 0;
    int m_stall_cnt = 0;
    bit m_to = 1'b0;

    logic [1:0] e_fa, e_fb;
    bit e_stall, e_bubble, e_flush, e_freeze;
    int e_left_nx;

    function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] rs);
        if (RUWr_me && rd_me == rs && !(ZERO_REG != 0 && rd_me == 0)) return 2'b01;
        if (RUWr_wb && rd_wb == rs && !(ZERO_REG != 0 && rd_wb == 0)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_eval();
        bit hz;
        e_fa = ref_fwd(rs1_ex);
        e_fb = ref_fwd(rs2_ex);
        hz = MemRd_ex && !(ZERO_REG != 0 && rd_ex == 0) &&
             ((use_rs1_de && rs1_de == rd_ex) || (use_rs2_de && rs2_de == rd_ex));
        e_stall = 0; e_bubble = 0; e_flush = 0; e_freeze = 0;
        e_left_nx = m_left;
        if (!rst) begin
            if (dmem_req_me && !dmem_ready) begin
                e_freeze = 1; e_stall = 1;
            end else if (br_taken_ex) begin
                e_flush = 1; e_bubble = 1; e_left_nx = 0;
            end else if (m_left > 0) begin
                e_stall = 1; e_left_nx = m_left - 1;
            end else if (hz) begin
                e_stall = 1; e_bubble = 1; e_left_nx = LOAD_LAT - 1;
            end
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            m_left = 0; m_wait = 0; m_stall_cnt = 0; m_to = 0;
        end else begin
            m_left = e_left_nx;
            if (e_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (e_freeze) begin
                m_wait++;
                if (m_wait >= TIMEOUT) m_to = 1;
            end else begin
                m_wait = 0;
            end
        end
    endtask

    // Inputs are stable at the falling edge; the model follows each rising edge.
    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_idle();
        rst = 0; RUWr_me = 0; RUWr_wb = 0;
        rd_me = '0; rd_wb = '0; rs1_ex = '0; rs2_ex = '0; rd_ex = '0;
        MemRd_ex = 0; rs1_de = '0; rs2_de = '0; use_rs1_de = 0; use_rs2_de = 0;
        br_taken_ex = 0; dmem_req_me = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        settle();
        advance();
        rst = 0;
    endtask

    task automatic set_load_use();
        MemRd_ex = 1; rd_ex = 5'd7; rs2_de = 5'd7; use_rs2_de = 1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1; set_load_use(); dmem_req_me = 1; dmem_ready = 0; br_taken_ex = 1;
        settle();
        n_checks++; if ({stall_pc, stall_de, bubble_ex, flush_de, freeze} !== 5'b0) begin
            n_errors++; $display("FAIL reset_ctrl: got %b exp 00000", {stall_pc, stall_de, bubble_ex, flush_de, freeze}); end
        advance();
        set_idle(); rst = 1;
        settle();
        n_checks++; if (stall_cnt !== '0) begin
            n_errors++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
        n_checks++; if (mem_timeout !== 1'b0) begin
            n_errors++; $display("FAIL reset_timeout: got %b exp 0", mem_timeout); end
        advance();
        rst = 0;
    endtask

    task automatic test_forward();
        do_reset();
        RUWr_me = 1; RUWr_wb = 1; rd_me = 5'd5; rd_wb = 5'd5; rs1_ex = 5'd5; rs2_ex = 5'd6;
        settle();
        n_checks++; if (FUASrc !== 2'b01) begin n_errors++; $display("FAIL fwd_me_prio A: got %b exp 01", FUASrc); end
        n_checks++; if (FUBSrc !== 2'b00) begin n_errors++; $display("FAIL fwd_none B: got %b exp 00", FUBSrc); end
        advance();
        RUWr_me = 0;
        settle();
        n_checks++; if (FUASrc !== 2'b10) begin n_errors++; $display("FAIL fwd_wb A: got %b exp 10", FUASrc); end
        advance();
        RUWr_me = 1; rd_me = '0; rd_wb = '0; rs1_ex = '0;
        settle();
        n_checks++; if (FUASrc !== 2'b00) begin n_errors++; $display("FAIL fwd_zero_reg A: got %b exp 00", FUASrc); end
        advance();
        for (int i = 0; i < 40; i++) begin
            RUWr_me = 1'($urandom_range(0, 1)); RUWr_wb = 1'($urandom_range(0, 1));
            rd_me = 5'($urandom_range(0, 3)); rd_wb = 5'($urandom_range(0, 3));
            rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
            settle();
            n_checks++; if (FUASrc !== e_fa) begin n_errors++; $display("FAIL fwd_rand A %0d: got %b exp %b", i, FUASrc, e_fa); end
            n_checks++; if (FUBSrc !== e_fb) begin n_errors++; $display("FAIL fwd_rand B %0d: got %b exp %b", i, FUBSrc, e_fb); end
            advance();
        end
        set_idle();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        for (int i = 0; i < 5; i++) begin
            settle();
            n_checks++; if (stall_pc !== (i < 3) || stall_de !== (i < 3)) begin
                n_errors++; $display("FAIL lu_stall cyc %0d: got %b%b exp %b", i, stall_pc, stall_de, (i < 3)); end
            n_checks++; if (bubble_ex !== (i == 0)) begin
                n_errors++; $display("FAIL lu_bubble cyc %0d: got %b exp %b", i, bubble_ex, (i == 0)); end
            advance();
            MemRd_ex = 0;   // EX now holds the bubble
        end
        settle();
        n_checks++; if (stall_cnt !== 5'd3) begin n_errors++; $display("FAIL lu_stall_cnt: got %0d exp 3", stall_cnt); end
        advance();
        set_idle();
    endtask

    task automatic test_freeze_in_stall();
        int seen;
        bit frz;
        seen = 0;
        do_reset();
        set_load_use();
        for (int i = 0; i < 9; i++) begin
            frz = (i >= 1 && i <= 4);
            dmem_req_me = frz; dmem_ready = !frz;
            settle();
            if (stall_pc === 1'b1) seen++;
            n_checks++; if (freeze !== frz) begin n_errors++; $display("FAIL frz_freeze cyc %0d: got %b exp %b", i, freeze, frz); end
            n_checks++; if (stall_pc !== (i < 7)) begin n_errors++; $display("FAIL frz_stall cyc %0d: got %b exp %b", i, stall_pc, (i < 7)); end
            n_checks++; if (bubble_ex !== (i == 0)) begin n_errors++; $display("FAIL frz_bubble cyc %0d: got %b exp %b", i, bubble_ex, (i == 0)); end
            advance();
            MemRd_ex = 0;
        end
        n_checks++; if (seen != 7) begin n_errors++; $display("FAIL frz_total_stalls: got %0d exp 7", seen); end
        settle();
        n_checks++; if (stall_cnt !== 5'd7) begin n_errors++; $display("FAIL frz_stall_cnt: got %0d exp 7", stall_cnt); end
        advance();
        set_idle();
    endtask

    task automatic test_branch_vs_hazard();
        do_reset();
        set_load_use(); br_taken_ex = 1;
        settle();
        n_checks++; if ({flush_de, bubble_ex, stall_pc, stall_de} !== 4'b1100) begin
            n_errors++; $display("FAIL br_hz ctrl: got %b exp 1100", {flush_de, bubble_ex, stall_pc, stall_de}); end
        advance();
        br_taken_ex = 0; MemRd_ex = 0;
        settle();
        n_checks++; if (stall_pc !== 1'b0) begin n_errors++; $display("FAIL br_hz next_idle: got %b exp 0", stall_pc); end
        advance();
        // Branch arriving while a load-use stall is still owed.
        set_load_use();
        settle();
        advance();
        MemRd_ex = 0; br_taken_ex = 1;
        settle();
        n_checks++; if ({flush_de, bubble_ex, stall_pc} !== 3'b110) begin
            n_errors++; $display("FAIL br_in_stall ctrl: got %b exp 110", {flush_de, bubble_ex, stall_pc}); end
        advance();
        br_taken_ex = 0;
        settle();
        n_checks++; if (stall_pc !== 1'b0) begin n_errors++; $display("FAIL br_in_stall next: got %b exp 0", stall_pc); end
        advance();
        set_idle();
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req_me = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) begin settle(); advance(); end
        dmem_ready = 1;
        settle(); advance();
        dmem_ready = 0;
        for (int i = 0; i < 7; i++) begin settle(); advance(); end
        settle();
        n_checks++; if (mem_timeout !== 1'b0) begin n_errors++; $display("FAIL to_after7: got %b exp 0", mem_timeout); end
        advance();
        settle();
        n_checks++; if (mem_timeout !== 1'b1) begin n_errors++; $display("FAIL to_after8: got %b exp 1", mem_timeout); end
        advance();
        dmem_ready = 1;
        for (int i = 0; i < 3; i++) begin settle(); advance(); end
        settle();
        n_checks++; if (mem_timeout !== 1'b1) begin n_errors++; $display("FAIL to_sticky: got %b exp 1", mem_timeout); end
        advance();
        rst = 1; dmem_ready = 0;
        settle();
        n_checks++; if (freeze !== 1'b0) begin n_errors++; $display("FAIL to_freeze_in_rst: got %b exp 0", freeze); end
        advance();
        rst = 0; dmem_ready = 1;
        settle();
        n_checks++; if (mem_timeout !== 1'b0) begin n_errors++; $display("FAIL to_cleared: got %b exp 0", mem_timeout); end
        advance();
        set_idle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_load_use();
        settle(); advance();
        MemRd_ex = 0; rst = 1; dmem_req_me = 1; dmem_ready = 0;
        settle();
        n_checks++; if ({stall_pc, stall_de, bubble_ex, flush_de, freeze} !== 5'b0) begin
            n_errors++; $display("FAIL rst_mid ctrl: got %b exp 00000", {stall_pc, stall_de, bubble_ex, flush_de, freeze}); end
        advance();
        rst = 0; dmem_req_me = 0; dmem_ready = 1;
        settle();
        n_checks++; if (stall_pc !== 1'b0) begin n_errors++; $display("FAIL rst_mid idle: got %b exp 0", stall_pc); end
        n_checks++; if (stall_cnt !== '0) begin n_errors++; $display("FAIL rst_mid stall_cnt: got %0d exp 0", stall_cnt); end
        advance();
        set_idle();
    endtask

    task automatic test_saturation();
        do_reset();
        dmem_req_me = 1; dmem_ready = 0;
        for (int i = 0; i < 40; i++) begin settle(); advance(); end
        settle();
        n_checks++; if (stall_cnt !== 5'd31) begin n_errors++; $display("FAIL sat_stall_cnt: got %0d exp 31", stall_cnt); end
        advance();
        set_idle();
    endtask

    task automatic test_random();
        int burst;
        burst = 0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            RUWr_me = 1'($urandom_range(0, 1)); RUWr_wb = 1'($urandom_range(0, 1));
            rd_me = 5'($urandom_range(0, 3)); rd_wb = 5'($urandom_range(0, 3));
            rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
            rd_ex = 5'($urandom_range(0, 3));
            rs1_de = 5'($urandom_range(0, 3)); rs2_de = 5'($urandom_range(0, 3));
            use_rs1_de = 1'($urandom_range(0, 1)); use_rs2_de = 1'($urandom_range(0, 1));
            MemRd_ex = ($urandom_range(0, 2) == 0);
            br_taken_ex = ($urandom_range(0, 9) == 0);
            if (burst > 0) begin
                dmem_req_me = 1; dmem_ready = 0; burst--;
            end else begin
                dmem_req_me = ($urandom_range(0, 3) == 0);
                dmem_ready = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 39) == 0) burst = $urandom_range(6, 12);
            end
            settle();
            n_checks++; if (FUASrc !== e_fa) begin n_errors++; $display("FAIL rand FUASrc %0d: got %b exp %b", i, FUASrc, e_fa); end
            n_checks++; if (FUBSrc !== e_fb) begin n_errors++; $display("FAIL rand FUBSrc %0d: got %b exp %b", i, FUBSrc, e_fb); end
            n_checks++; if (stall_pc !== e_stall || stall_de !== e_stall) begin
                n_errors++; $display("FAIL rand stall %0d: got %b%b exp %b", i, stall_pc, stall_de, e_stall); end
            n_checks++; if (bubble_ex !== e_bubble) begin n_errors++; $display("FAIL rand bubble_ex %0d: got %b exp %b", i, bubble_ex, e_bubble); end
            n_checks++; if (flush_de !== e_flush) begin n_errors++; $display("FAIL rand flush_de %0d: got %b exp %b", i, flush_de, e_flush); end
            n_checks++; if (freeze !== e_freeze) begin n_errors++; $display("FAIL rand freeze %0d: got %b exp %b", i, freeze, e_freeze); end
            n_checks++; if (stall_cnt !== CNT_W'(m_stall_cnt)) begin
                n_errors++; $display("FAIL rand stall_cnt %0d: got %0d exp %0d", i, stall_cnt, m_stall_cnt); end
            n_checks++; if (mem_timeout !== m_to) begin n_errors++; $display("FAIL rand mem_timeout %0d: got %b exp %b", i, mem_timeout, m_to); end
            advance();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_forward();
        test_load_use();
        test_freeze_in_stall();
        test_branch_vs_hazard();
        test_timeout();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_forward_unit
`default_nettype wire
